// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage. The control unit uses the
// same pc_op encodings.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PC_CLR  = 2'b00,
    PC_BR   = 2'b01,
    PC_INC  = 2'b10,
    PC_HOLD = 2'b11
  } pc_op_e;

  localparam int PC_W_DEF      = 8;
  localparam int RESET_VEC_DEF = 0;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a circular LIFO. When it is full, a push overwrites
// the oldest entry. The flags are sticky and registered.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] tp, tp_nxt, wr_idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wr_en, ovf_nxt, unf_nxt;

  assign top = mem[tp];

  always_comb begin
    cnt_nxt = cnt;
    tp_nxt  = tp;
    wr_en   = 1'b0;
    wr_idx  = tp + PTR_ONE;
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (clear) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else if (push && pop && (cnt != '0)) begin
      // A call and a return in the same cycle replace the top in place.
      wr_en  = 1'b1;
      wr_idx = tp;
    end else begin
      if (pop) begin
        if (cnt == '0) begin
          unf_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          tp_nxt  = tp - PTR_ONE;
        end
      end
      if (push) begin
        wr_en  = 1'b1;
        tp_nxt = tp + PTR_ONE;
        if (cnt == CNT_MAX) ovf_nxt = 1'b1;
        else                cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tp    <= tp_nxt;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CNT_MAX);
      empty <= (cnt_nxt == '0);
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
      if (wr_en) mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: the PC register, the branch target mux, and the
// return-address stack for call and return.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEF,
  parameter int          IMM_W     = 8,
  parameter int          RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        pc_op,
  input  logic              flag,
  input  logic [IMM_W-1:0]  imm,
  input  logic [PC_W-1:0]   reg_target,
  input  logic              push_en,
  input  logic              pop_en,
  output logic [PC_W-1:0]   pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [PC_W-1:0] pc_inc, imm_ext, ras_top, br_target;
  logic            is_br, is_clr;

  assign is_br   = (pc_op == PC_BR);
  assign is_clr  = (pc_op == PC_CLR);
  assign pc_inc  = pc + PC_W'(1);
  assign imm_ext = PC_W'($signed(imm));

  // Branch base is the branch instruction's own PC.
  assign br_target = flag ? reg_target : pc + imm_ext;

  pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .clear (is_clr),
    .push  (is_br && push_en),
    .pop   (is_br && pop_en),
    .din   (pc_inc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VEC;
    end else begin
      case (pc_op_e'(pc_op))
        PC_CLR:  pc <= RESET_VEC;
        PC_INC:  pc <= pc_inc;
        PC_HOLD: pc <= pc;
        PC_BR: begin
          if (pop_en) begin
            if (!ras_empty) pc <= ras_top;
          end else begin
            pc <= br_target;
          end
        end
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the multi-cycle control FSM.
- Consumes the 2-bit pc_op command and branch flag, and produces the instruction address used during Fetch.
- Holds the PC register, computes relative and register-indirect branch targets, and keeps a small return-address stack (RAS) for call/return.
- All outputs are registered.

Parameters:
- PC_W, 8, PC/instruction address width
- IMM_W, 8, branch offset width; sign-extended to PC_W
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
- RESET_VEC, 0, PC value after reset or clear

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pc_op  in  2  command: 00 clear, 01 branch, 10 increment, 11 hold
- flag  in  1  branch source select, sampled when pc_op==01: 0 = PC-relative immediate, 1 = register target
- imm  in  IMM_W  signed branch offset
- reg_target  in  PC_W  absolute branch target from register file
- push_en  in  1  call: push return address; honoured only with pc_op==01
- pop_en  in  1  return: branch to RAS top; honoured only with pc_op==01
- pc  out  PC_W  current PC
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky: push attempted while full
- ras_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset low, asynchronous):
  - pc = RESET_VEC, RAS count = 0
  - ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0
  - Release is synchronous to clk.
- Reset asserted mid-operation aborts any branch or push; no partial update survives.
- pc_op is acted on every rising edge; effects are visible on pc one cycle later. Latency is 1 cycle for every command.
- pc_op 00 (clear): pc <= RESET_VEC; RAS emptied; ras_ovf and ras_unf cleared. push_en and pop_en are ignored.
- pc_op 10 (increment): pc <= pc + 1, modulo 2^PC_W, so all-ones wraps to 0.
- pc_op 11 (hold): pc unchanged; RAS unchanged.
- pc_op 01 (branch), evaluated in priority order:
  1. pop_en=1, RAS non-empty: target = RAS top; count decrements.
  2. pop_en=1, RAS empty: pc holds; ras_unf <= 1.
  3. pop_en=0, flag=0: target = pc + sext(imm), modulo 2^PC_W. The base is the branch instruction's own PC; the FSM does not increment before the branch.
  4. pop_en=0, flag=1: target = reg_target.
- push_en with pc_op==01: push the return address pc + 1 (wrapped), then take the target chosen above.
- Push while full:
  - The oldest entry is overwritten (circular buffer) and ras_ovf <= 1.
  - Count stays RAS_DEPTH.
- push_en and pop_en together on a non-empty RAS:
  - Target = old top; pc+1 replaces the top; count unchanged.
  - If the RAS is empty: unf rule applies (pc holds, ras_unf <= 1), and the push then proceeds normally (count becomes 1).
- push_en and pop_en with pc_op != 01: ignored.
- ras_full and ras_empty reflect the post-update count. Sticky flags clear only on reset or pc_op 00.
- Undriven or X pc_op is not defined; the bench must not drive it.

Decomposition:
- Shared package:
  - pc_op encodings: PC_CLR=2'b00, PC_BR=2'b01, PC_INC=2'b10, PC_HOLD=2'b11, which the control unit also uses
  - Default PC_W and RESET_VEC
- One natural sub-module, pc_ras:
  - Circular LIFO with top pointer and count
  - Ports: push, pop, din, top, full, empty, ovf, unf, clear
  - pc_unit instantiates it and keeps the PC register and target mux itself.

Test Plan:
- Reset low mid-count (pc=0x05), then release, then 3x pc_op=10 -> pc reads 0x00 immediately on reset, then 0x01, 0x02, 0x03; all RAS flags at reset values.
- Hold pc at 0xFF, pc_op=10 -> pc=0x00 (wrap); pc_op=11 for 4 cycles -> pc stays 0x00.
- pc=0x10: pc_op=01, flag=0, imm=0xFC -> pc=0x0C; then pc_op=01, flag=1, reg_target=0x80 -> pc=0x80.
- Call/return: pc=0x20, pc_op=01, push_en, flag=1, reg_target=0x40 -> pc=0x40, ras_empty=0; then pc_op=01, pop_en -> pc=0x21, ras_empty=1.
- Overflow: 5 pushes (returns 0x01,0x02,0x03,0x04,0x05) with DEPTH 4 -> ras_full=1, ras_ovf=1; 4 pops yield 0x05,0x04,0x03,0x02; ras_empty=1.
- Underflow: pop on empty at pc=0x33 -> pc stays 0x33, ras_unf=1; pc_op=00 -> pc=RESET_VEC, ras_unf=0.
